// File: rtl/stream_arbiter.sv
// stream_arbiter: 4-way round-robin stream arbiter feeding a single registered output beat.
// Packet locking (hold the grant until in_last) is built only when STREAM_ARBITER_LOCK_EN is defined.
module stream_arbiter #(
    parameter int DATA_W = 32,
    parameter int N      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        in_valid,
    output logic [N-1:0]        in_ready,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic [N-1:0]        in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_last,
    output logic [1:0]          out_src
);
    logic              out_valid_q, out_last_q;
    logic [DATA_W-1:0] out_data_q;
    logic [1:0]        out_src_q, rr_q, rr_d, g, idx;
    logic              hit, load_en, fire;
`ifdef STREAM_ARBITER_LOCK_EN
    typedef enum logic {ARB, LOCK} state_e;
    state_e     state_q;
    logic [1:0] lock_q;
`endif

    // descending scan so the candidate closest to rr_q is the one that sticks
    always_comb begin
        g   = rr_q;
        hit = 1'b0;
        idx = rr_q;
        for (int k = N - 1; k >= 0; k--) begin
            idx = rr_q + 2'(k);
            if (in_valid[idx]) begin
                g   = idx;
                hit = 1'b1;
            end
        end
`ifdef STREAM_ARBITER_LOCK_EN
        if (state_q == LOCK) begin
            g   = lock_q;
            hit = in_valid[lock_q];
        end
`endif
    end

    assign load_en   = !out_valid_q || out_ready;
    assign fire      = hit && load_en && !rst;
    assign in_ready  = fire ? N'(1) << g : '0;
    assign rr_d      = g + 2'd1;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= 2'd0;
            rr_q        <= 2'd0;
`ifdef STREAM_ARBITER_LOCK_EN
            state_q     <= ARB;
            lock_q      <= 2'd0;
`endif
        end else begin
            if (load_en) out_valid_q <= fire;
            if (fire) begin
                out_data_q <= in_data[g*DATA_W +: DATA_W];
                out_last_q <= in_last[g];
                out_src_q  <= g;
`ifdef STREAM_ARBITER_LOCK_EN
                if (!in_last[g]) begin
                    state_q <= LOCK;
                    lock_q  <= g;
                end else begin
                    state_q <= ARB;
                    rr_q    <= rr_d;
                end
`else
                rr_q <= rr_d;
`endif
            end
        end
    end
endmodule

// File: tb/tb_stream_arbiter.sv
// tb_stream_arbiter: randomized scoreboard bench for stream_arbiter against a queue-based reference model.
module tb_stream_arbiter;
    logic         clk = 1'b0, rst = 1'b1;
    logic [3:0]   in_valid = '0, in_ready, in_last = '0;
    logic [127:0] in_data = '0;
    logic         out_valid, out_ready = 1'b0, out_last;
    logic [31:0]  out_data;
    logic [1:0]   out_src;

    typedef struct packed {logic [31:0] d; logic l; logic [1:0] s;} beat_t;
    beat_t sb[$];
    int    checks = 0, errors = 0;
    int    ptr = 0, owner = -1;
    bit    occ = 0;
`ifdef STREAM_ARBITER_LOCK_EN
    localparam bit LOCKED = 1'b1;
`else
    localparam bit LOCKED = 1'b0;
`endif

    stream_arbiter #(.DATA_W(32), .N(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_src(out_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: owner holds the grant until a last beat, otherwise first valid from ptr upward mod 4
    task automatic model();
        int  g = 0;
        bit  hit = 0, le;
        beat_t b;
        le = !occ || out_ready;
        if (owner >= 0) begin
            g   = owner;
            hit = in_valid[owner];
        end else
            for (int k = 0; k < 4; k++)
                if (!hit && in_valid[(ptr + k) % 4]) begin
                    g   = (ptr + k) % 4;
                    hit = 1;
                end
        check("in_ready", 64'(in_ready), (hit && le) ? 64'(1 << g) : 64'd0);
        if (hit && le) begin
            b.d = in_data[g*32 +: 32];
            b.l = in_last[g];
            b.s = 2'(g);
            sb.push_back(b);
            if (LOCKED && !in_last[g]) owner = g;
            else begin
                owner = -1;
                ptr   = (g + 1) % 4;
            end
        end
        occ = (hit && le) ? 1'b1 : (out_ready ? 1'b0 : occ);
    endtask

    always @(negedge clk) if (!rst) begin
        beat_t b;
        check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (out_valid && out_ready && sb.size() != 0) begin
            b = sb.pop_front();
            check("out_data", 64'(out_data), 64'(b.d));
            check("out_last", 64'(out_last), 64'(b.l));
            check("out_src", 64'(out_src), 64'(b.s));
        end
    end

    task automatic run();
        @(negedge clk);
        #1 model();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic r);
        in_valid  = v;
        in_last   = l;
        out_ready = r;
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        run();
    endtask

    task automatic model_reset();
        sb.delete();
        ptr   = 0;
        owner = -1;
        occ   = 0;
    endtask

    initial begin
        in_valid = 4'b1111;
        #1;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_data", 64'(out_data), 0);
        check("rst_out_last", 64'(out_last), 0);
        check("rst_out_src", 64'(out_src), 0);
        check("rst_in_ready", 64'(in_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 4'b0001;
        in_last = 4'b1111;
        out_ready = 1'b1;
        in_data = '0;
        in_data[31:0] = 32'hA5A5A5A5;
        run();
        check("first_out_valid", 64'(out_valid), 1);
        check("first_out_data", 64'(out_data), 64'h00000000A5A5A5A5);
        check("first_out_src", 64'(out_src), 0);
        for (int i = 0; i < 8; i++) cyc(4'b1111, 4'b1111, 1'b1);
        cyc(4'b0001, 4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) cyc(4'b0110, 4'b1111, 1'b0);
        cyc(4'b0110, 4'b1111, 1'b1);
        cyc(4'b0000, 4'b1111, 1'b1);
        cyc(4'b0000, 4'b1111, 1'b1);
        cyc(4'b0100, 4'b0000, 1'b1);
        cyc(4'b0101, 4'b0000, 1'b1);
        cyc(4'b0101, 4'b0100, 1'b1);
        cyc(4'b0101, 4'b0100, 1'b1);
        cyc(4'b0101, 4'b0101, 1'b1);
        cyc(4'b0000, 4'b1111, 1'b1);
        cyc(4'b0100, 4'b0000, 1'b0);
        cyc(4'b0100, 4'b0000, 1'b0);
        rst = 1'b1;
        #1;
        check("async_out_valid", 64'(out_valid), 0);
        check("async_in_ready", 64'(in_ready), 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(4'b1111, 4'b1111, 1'b1);
        check("post_rst_src", 64'(out_src), 0);
        for (int i = 0; i < 2000; i++)
            cyc(4'($urandom), 4'($urandom | $urandom), 1'($urandom_range(0, 3) != 0));
        cyc(4'b0000, 4'b1111, 1'b1);
        cyc(4'b0000, 4'b1111, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
